// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, result-select codes, FSM encodings and lane-mask helper for mem_access.
package mem_access_pkg;
    localparam int WORD_W     = 32;
    localparam int MEM_ADDR_W = 30;
    localparam int MEM_SEL_W  = 4;
    localparam int REG_ADDR_W = 5;
    localparam logic MEM_SEL_REGVAL = 1'b0;
    localparam logic MEM_SEL_MEMVAL = 1'b1;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    typedef enum logic {MEM_ACC_IDLE = 1'b0, MEM_ACC_BUSY = 1'b1} state_t;
    function automatic logic [WORD_W-1:0] lane_mask(input logic [MEM_SEL_W-1:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: shifts the selected load lanes down to bit 0 and zero-extends.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0]    rdata,
    input  logic [MEM_SEL_W-1:0] sel,
    output logic [WORD_W-1:0]    aligned
);
    always_comb begin
        aligned = sel == 4'b0001 ? {24'b0, rdata[7:0]}   :
                  sel == 4'b0010 ? {24'b0, rdata[15:8]}  :
                  sel == 4'b0100 ? {24'b0, rdata[23:16]} :
                  sel == 4'b1000 ? {24'b0, rdata[31:24]} :
                  sel == 4'b0011 ? {16'b0, rdata[15:0]}  :
                  sel == 4'b1100 ? {16'b0, rdata[31:16]} :
                                   rdata & lane_mask(sel);
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory-stage req/ack bus master with stall and registered write-back.
// Optional bus-wait timeout enabled by MEM_ACCESS_TIMEOUT_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_memWriteEnable,
    input  logic                  mem_memReadEnable,
    input  logic [MEM_ADDR_W-1:0] mem_memAddr,
    input  logic [MEM_SEL_W-1:0]  mem_memSel,
    input  logic [WORD_W-1:0]     mem_result,
    input  logic [REG_ADDR_W-1:0] mem_regDest,
    input  logic                  mem_resultSel,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [MEM_ADDR_W-1:0] bus_addr,
    output logic [MEM_SEL_W-1:0]  bus_sel,
    output logic [WORD_W-1:0]     bus_wdata,
    input  logic [WORD_W-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output logic                  stall_req,
    output logic                  wb_writeEnable,
    output logic [REG_ADDR_W-1:0] wb_regDest,
    output logic [WORD_W-1:0]     wb_data,
    output logic                  bus_err
);
    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [MEM_SEL_W-1:0]  sel_q, sel_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic                  wb_we_q, wb_we_d;
    logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [WORD_W-1:0]     wb_data_q, wb_data_d;
    logic [WORD_W-1:0]     aligned;
    logic                  expire;
    mem_load_align u_align (.rdata(bus_rdata), .sel(sel_q), .aligned(aligned));
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    assign expire = state_q == MEM_ACC_BUSY && !bus_ack && cnt_q == 16'(TIMEOUT_CYCLES - 1);
    assign cnt_d  = state_q == MEM_ACC_BUSY ? cnt_q + 16'd1 : 16'd0;
    assign err_d  = expire;
    assign bus_err = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign expire  = 1'b0;
    assign bus_err = 1'b0;
`endif
    assign bus_req        = state_q == MEM_ACC_BUSY;
    assign bus_we         = we_q;
    assign bus_addr       = addr_q;
    assign bus_sel        = sel_q;
    assign bus_wdata      = wdata_q;
    assign wb_writeEnable = wb_we_q;
    assign wb_regDest     = wb_dest_q;
    assign wb_data        = wb_data_q;
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        dest_d    = dest_q;
        wb_we_d   = 1'b0;
        wb_dest_d = wb_dest_q;
        wb_data_d = wb_data_q;
        stall_req = 1'b0;
        if (state_q == MEM_ACC_IDLE) begin
            if (mem_memWriteEnable || mem_memReadEnable) begin
                state_d   = MEM_ACC_BUSY;
                we_d      = mem_memWriteEnable;
                addr_d    = mem_memAddr;
                sel_d     = mem_memSel;
                wdata_d   = mem_result;
                dest_d    = mem_regDest;
                stall_req = 1'b1;
            end else begin
                wb_we_d   = mem_regDest != REG_ZERO;
                wb_dest_d = mem_regDest;
                wb_data_d = mem_resultSel == MEM_SEL_MEMVAL ? mem_result : mem_result;
            end
        end else if (bus_ack) begin
            state_d = MEM_ACC_IDLE;
            if (!we_q) begin
                wb_we_d   = dest_q != REG_ZERO;
                wb_dest_d = dest_q;
                wb_data_d = aligned;
            end
        end else if (expire) begin
            state_d = MEM_ACC_IDLE;
        end else begin
            stall_req = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MEM_ACC_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            dest_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            dest_q    <= dest_d;
            wb_we_q   <= wb_we_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
        end
    end
endmodule
